exhaustive_vector_checker: RTL and testbench

- Parametrised, self-checking exhaustive stimulus engine for N_IN-input combinational gates.
- Steps a DUT through all 2^N_IN input combinations in binary or Gray order and holds each vector for DWELL clocks.
- On the last dwell cycle of each vector it compares the DUT output against a golden-model output, then counts mismatches and captures the first failing vector.
- Sits between a gate under test (for example a 4-input NAND) and its golden reference, replacing free-running delay-based stimulus with clocked, checked runs.

---
 rtl/exhaustive_vector_checker.sv | 87 ++++++++
 tb/tb_exhaustive_vector_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/exhaustive_vector_checker.sv
// exhaustive_vector_checker: walks a gate through every input vector and checks its output against a golden model
module exhaustive_vector_checker #(
    parameter int N_IN  = 4,
    parameter int DWELL = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            gray_mode,
    input  logic            dut_in,
    input  logic            exp_in,
    output logic [N_IN-1:0] pattern_out,
    output logic            busy,
    output logic            done,
    output logic            err_flag,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_vec
);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [N_IN-1:0] idx, idx_inc;
    logic [DW-1:0]   dcnt;
    logic            mode_q, samp, last, go, kill;

    function automatic logic [N_IN-1:0] enc(input logic [N_IN-1:0] v, input logic g);
        return g ? v ^ (v >> 1) : v;
    endfunction

    assign samp    = state == RUN && dcnt == DW'(DWELL - 1);
    assign last    = idx == '1;
    assign kill    = abort && state != IDLE;
    assign go      = start && !abort && state != RUN;
    assign idx_inc = idx + N_IN'(1);
    assign busy    = state == RUN;
    assign done    = state == DONE;

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nxt;

    // abort wins over start; the final sampling edge moves RUN into DONE
    always_comb begin
        state_nxt = state;
        if (kill)             state_nxt = IDLE;
        else if (go)          state_nxt = RUN;
        else if (samp && last) state_nxt = DONE;
    end

    // vector stepping, dwell counting and mismatch capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst || kill) begin
            idx           <= '0;
            dcnt          <= '0;
            mode_q        <= 1'b0;
            pattern_out   <= '0;
            err_flag      <= 1'b0;
            err_count     <= '0;
            first_err_vec <= '0;
        end else if (go) begin
            idx           <= '0;
            dcnt          <= '0;
            mode_q        <= gray_mode;
            pattern_out   <= '0;
            err_flag      <= 1'b0;
            err_count     <= '0;
            first_err_vec <= '0;
        end else if (state == RUN) begin
            dcnt <= samp ? '0 : dcnt + DW'(1);
            if (samp && dut_in != exp_in) begin
                err_count <= err_count + (N_IN + 1)'(1);
                if (!err_flag) begin
                    err_flag      <= 1'b1;
                    first_err_vec <= pattern_out;
                end
            end
            if (samp && !last) begin
                idx         <= idx_inc;
                pattern_out <= enc(idx_inc, mode_q);
            end
        end
    end
endmodule

// File: tb/tb_exhaustive_vector_checker.sv
// tb_exhaustive_vector_checker: table-driven and randomized checks of the exhaustive vector checker
module tb_exhaustive_vector_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, abort_a = 1'b0, gray_a = 1'b0;
    logic        dut_a, exp_a, busy_a, done_a, flag_a;
    logic [3:0]  pat_a, first_a;
    logic [4:0]  cnt_a;
    int          sel_a = 0;
    logic [15:0] mask_a = '0;

    logic        start_b = 1'b0, abort_b = 1'b0, gray_b = 1'b0;
    logic        dut_b, exp_b, busy_b, done_b, flag_b;
    logic [2:0]  pat_b, first_b;
    logic [3:0]  cnt_b;
    logic [7:0]  mask_b = '0;

    int checks = 0;
    int errors = 0;

    function automatic logic dut_fn(input int sel, input logic [15:0] m, input logic [3:0] p);
        case (sel)
            0:       return ~&p;
            1:       return 1'b1;
            2:       return &p;
            default: return ~&p ^ m[p];
        endcase
    endfunction

    function automatic int gcode(input int k, input bit g);
        return g ? (k ^ (k >> 1)) : k;
    endfunction

    assign exp_a = ~&pat_a;
    assign dut_a = dut_fn(sel_a, mask_a, pat_a);
    assign exp_b = ~&pat_b;
    assign dut_b = ~&pat_b ^ mask_b[pat_b];

    exhaustive_vector_checker #(.N_IN(4), .DWELL(2)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .gray_mode(gray_a),
        .dut_in(dut_a), .exp_in(exp_a), .pattern_out(pat_a), .busy(busy_a), .done(done_a),
        .err_flag(flag_a), .err_count(cnt_a), .first_err_vec(first_a)
    );

    exhaustive_vector_checker #(.N_IN(3), .DWELL(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .gray_mode(gray_b),
        .dut_in(dut_b), .exp_in(exp_b), .pattern_out(pat_b), .busy(busy_b), .done(done_b),
        .err_flag(flag_b), .err_count(cnt_b), .first_err_vec(first_b)
    );

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    typedef struct {
        string       name;
        bit          g;
        int          sel;
        logic [15:0] mask;
        int          ecnt;
        int          efirst;
        bit          eflag;
    } vec_t;

    vec_t tbl[$];

    // one full run on the 4-input checker, entered and left at 1 time unit after an edge
    task automatic run_a(input vec_t v);
        int run_err = 0;
        sel_a   = v.sel;
        mask_a  = v.mask;
        gray_a  = v.g;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        gray_a  = ~v.g;
        for (int k = 0; k < 16; k++) begin
            int p = gcode(k, v.g);
            chk({v.name, " pattern"}, int'(pat_a), p);
            chk({v.name, " busy"}, int'(busy_a), 1);
            chk({v.name, " running count"}, int'(cnt_a), run_err);
            if (dut_fn(v.sel, v.mask, 4'(p)) != ~&(4'(p))) run_err++;
            repeat (2) @(posedge clk);
            #1;
        end
        chk({v.name, " done"}, int'(done_a), 1);
        chk({v.name, " busy end"}, int'(busy_a), 0);
        chk({v.name, " err_count"}, int'(cnt_a), v.ecnt);
        chk({v.name, " err_flag"}, int'(flag_a), int'(v.eflag));
        if (v.eflag) chk({v.name, " first_err_vec"}, int'(first_a), v.efirst);
        @(posedge clk); #1;
        chk({v.name, " held pattern"}, int'(pat_a), gcode(15, v.g));
        chk({v.name, " held done"}, int'(done_a), 1);
    endtask

    initial begin
        vec_t v;
        int b_err, b_first;
        tbl.push_back('{"bin_nand", 1'b0, 0, 16'h0, 0, 0, 1'b0});
        tbl.push_back('{"bin_one", 1'b0, 1, 16'h0, 1, 15, 1'b1});
        tbl.push_back('{"bin_one_again", 1'b0, 1, 16'h0, 1, 15, 1'b1});
        tbl.push_back('{"gray_and", 1'b1, 2, 16'h0, 16, 0, 1'b1});
        for (int r = 0; r < 4; r++) begin
            v.name   = $sformatf("rand%0d", r);
            v.g      = 1'($urandom_range(0, 1));
            v.sel    = 3;
            v.mask   = (r == 0) ? 16'h8000 : 16'($urandom);
            v.ecnt   = $countones(v.mask);
            v.eflag  = v.mask != 0;
            v.efirst = 0;
            for (int k = 15; k >= 0; k--)
                if (v.mask[gcode(k, v.g)]) v.efirst = gcode(k, v.g);
            tbl.push_back(v);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("reset pattern_a", int'(pat_a), 0);
        chk("reset busy_a", int'(busy_a), 0);
        chk("reset done_a", int'(done_a), 0);
        chk("reset cnt_a", int'(cnt_a), 0);
        chk("reset flag_a", int'(flag_a), 0);
        chk("reset pattern_b", int'(pat_b), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) run_a(tbl[i]);

        // DWELL=1: every edge samples; mid-run mode toggle and start pulse are ignored
        mask_b  = 8'($urandom);
        b_err   = 0;
        b_first = -1;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("dw1 pattern", int'(pat_b), k);
            chk("dw1 running count", int'(cnt_b), b_err);
            if (mask_b[k]) begin
                b_err++;
                if (b_first < 0) b_first = k;
            end
            if (k == 2) gray_b = 1'b1;
            start_b = (k == 3);
            @(posedge clk); #1;
        end
        start_b = 1'b0;
        chk("dw1 done", int'(done_b), 1);
        chk("dw1 busy", int'(busy_b), 0);
        chk("dw1 err_count", int'(cnt_b), b_err);
        chk("dw1 err_flag", int'(flag_b), int'(b_err != 0));
        if (b_err != 0) chk("dw1 first_err_vec", int'(first_b), b_first);

        // abort at E10 of a failing run from DONE
        gray_a  = 1'b1;
        sel_a   = 2;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("pre-abort count", int'(cnt_a), 4);
        abort_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        chk("abort busy", int'(busy_a), 0);
        chk("abort done", int'(done_a), 0);
        chk("abort pattern", int'(pat_a), 0);
        chk("abort count", int'(cnt_a), 0);
        chk("abort flag", int'(flag_a), 0);
        abort_a = 1'b1;
        start_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        start_a = 1'b0;
        chk("abort beats start", int'(busy_a), 0);

        // asynchronous reset mid-run
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre-reset count", int'(cnt_a), 2);
        #3;
        rst = 1'b1;
        #1;
        chk("async rst busy", int'(busy_a), 0);
        chk("async rst pattern", int'(pat_a), 0);
        chk("async rst count", int'(cnt_a), 0);
        chk("async rst flag", int'(flag_a), 0);
        chk("async rst first", int'(first_a), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
